// File: rtl/sys_rst_pkg.sv
// Shared types and constants for the system reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sys_rst_pkg;

  // Sequencer states. The encoding is visible on the seq_state debug port.
  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_seq_state_t;

  // Depth of every clock-domain-crossing synchronizer in this block.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop synchronizer for either a reset or a level signal into clock.
// Latency: SYNC_STAGES clock edges for a change on din; arst acts immediately.
// Backpressure: none; this is a free-running level path.
//
// Ports:
//   clock - destination clock
//   arst  - asynchronous active-high clear of the synchronizer chain
//   din   - level to synchronize (tie low when used as a reset synchronizer)
//   dout  - synchronized level
//
// ASYNC_ASSERT = 1: arst forces dout high at once and its release reaches
//   dout only after SYNC_STAGES edges (async assert, sync deassert).
// ASYNC_ASSERT = 0: plain data synchronizer; arst clears the chain to 0 so
//   the output never reads a stale or unknown level after reset.
module rst_sync_2ff
  import sys_rst_pkg::*;
#(
  parameter bit ASYNC_ASSERT = 1'b1
) (
  input  logic clock,
  input  logic arst,
  input  logic din,
  output logic dout
);

  localparam logic [SYNC_STAGES-1:0] RST_VAL = ASYNC_ASSERT ? '1 : '0;

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      sync_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sys_reset_sequencer.sv
// Staged reset release: core, then interconnect, then peripherals, gated on a filtered PLL lock.
// Latency: with defaults and stable lock, rst_out[0] falls 20 edges after internal reset release.
// Backpressure: none; lock loss (or soft request) re-asserts every stage on the next edge.
//
// Ports:
//   clock        - free-running global system clock
//   rst          - asynchronous active-high reset input
//   pll_locked   - asynchronous PLL lock flag
//   rst_out      - active-high stage resets, index 0 released first
//   seq_done     - high once every stage is released
//   seq_state    - current sequencer state (debug)
//   soft_rst_req - (only with SYS_RST_SOFT_REQ_EN) synchronous resequence request
//
// Build option: define SYS_RST_SOFT_REQ_EN to add the soft_rst_req input.
module sys_reset_sequencer
  import sys_rst_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int LOCK_FILTER = 4,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic [1:0]            seq_state
`ifdef SYS_RST_SOFT_REQ_EN
  ,
  input  logic                  soft_rst_req
`endif
);

  // Reject configurations the counters cannot represent.
  if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || LOCK_FILTER < 1 || STAGE_GAP < 1) begin : g_bad_min
    $error("sys_reset_sequencer: NUM_STAGES, HOLD_CYCLES, LOCK_FILTER and STAGE_GAP must be >= 1");
  end
  if ((HOLD_CYCLES >> CNT_W) != 0 || (LOCK_FILTER >> CNT_W) != 0 ||
      (STAGE_GAP >> CNT_W) != 0) begin : g_bad_width
    $error("sys_reset_sequencer: CNT_W too narrow for HOLD_CYCLES/LOCK_FILTER/STAGE_GAP");
  end

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  // Terminal counts: the action fires on the edge the count would reach N.
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_END = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic rst_i;
  logic lock_s;

  rst_sync_2ff #(.ASYNC_ASSERT(1'b1)) u_rst_sync (
    .clock (clock),
    .arst  (rst),
    .din   (1'b0),
    .dout  (rst_i)
  );

  rst_sync_2ff #(.ASYNC_ASSERT(1'b0)) u_lock_sync (
    .clock (clock),
    .arst  (rst),
    .din   (pll_locked),
    .dout  (lock_s)
  );

  rst_seq_state_t        state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      lock_cnt;
  logic [IDX_W-1:0]      idx;
  logic [NUM_STAGES-1:0] rst_out_q;
  logic                  seq_done_q;
  logic                  abort;

  // Losing lock once any stage is released restarts the whole sequence;
  // in WAIT_LOCK a dropout only restarts the lock filter.
  always_comb begin
    abort = !lock_s && (state == RELEASE || state == RUN);
`ifdef SYS_RST_SOFT_REQ_EN
    abort = abort | soft_rst_req;
`endif
  end

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      state      <= HOLD;
      cnt        <= '0;
      lock_cnt   <= '0;
      idx        <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
    end else if (abort) begin
      state      <= HOLD;
      cnt        <= '0;
      lock_cnt   <= '0;
      idx        <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_END) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        WAIT_LOCK: begin
          if (!lock_s) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_END) begin
            rst_out_q[0] <= 1'b0;
            lock_cnt     <= '0;
            cnt          <= '0;
            if (NUM_STAGES == 1) begin
              state <= RUN;
            end else begin
              state <= RELEASE;
              idx   <= IDX_W'(1);
            end
          end else begin
            lock_cnt <= sat_inc(lock_cnt);
          end
        end

        RELEASE: begin
          if (cnt == GAP_END) begin
            rst_out_q[idx] <= 1'b0;
            cnt            <= '0;
            if (idx == IDX_LAST) begin
              state <= RUN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        RUN: begin
          // Set on the first RUN edge, one cycle after the last release.
          seq_done_q <= 1'b1;
        end

        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  assign rst_out   = rst_out_q;
  assign seq_done  = seq_done_q;
  assign seq_state = state;

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Directed bench for sys_reset_sequencer: default build plus a minimal-parameter instance.
// Cycle index k counts rising edges after t0 (2nd edge after rst falls); checks sample 1 time unit after the edge.
// Inputs are driven right after the edge in which their k is reached.
module tb_sys_reset_sequencer;

  logic clock = 1'b0;
  logic rst = 1'b0;
  logic pll_locked = 1'b1;
`ifdef SYS_RST_SOFT_REQ_EN
  logic soft_rst_req = 1'b0;
`endif

  logic [2:0] rst_out;
  logic       seq_done;
  logic [1:0] seq_state;
  logic [0:0] c_rst_out;
  logic       c_seq_done;
  logic [1:0] c_seq_state;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  always #5 clock = ~clock;

  sys_reset_sequencer dut (
    .clock        (clock),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .rst_out      (rst_out),
    .seq_done     (seq_done),
    .seq_state    (seq_state)
`ifdef SYS_RST_SOFT_REQ_EN
    ,
    .soft_rst_req (soft_rst_req)
`endif
  );

  sys_reset_sequencer #(
    .NUM_STAGES  (1),
    .HOLD_CYCLES (1),
    .LOCK_FILTER (1),
    .STAGE_GAP   (1),
    .CNT_W       (16)
  ) dut_min (
    .clock        (clock),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .rst_out      (c_rst_out),
    .seq_done     (c_seq_done),
    .seq_state    (c_seq_state)
`ifdef SYS_RST_SOFT_REQ_EN
    ,
    .soft_rst_req (soft_rst_req)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step();
    tick();
    k++;
  endtask

  // Called just after an edge: drop rst and advance to t0.
  task automatic start_seq();
    rst = 1'b0;
    tick();
    tick();
    k = 0;
  endtask

  initial begin
    // Reset asserted between edges must act with no clock.
    #1 rst = 1'b1;
    #1;
    check("async_reset_rst_out", 32'(rst_out), 32'h7);
    check("async_reset_done", 32'(seq_done), 32'h0);
    repeat (3) tick();
    check("reset_state", 32'(seq_state), 32'h0);
    check("reset_min_rst_out", 32'(c_rst_out), 32'h1);

    // Nominal sequence with lock stable, then lock loss in RUN at t0+50.
    start_seq();
    check("t0_state_hold", 32'(seq_state), 32'h0);
    check("t0_rst_out", 32'(rst_out), 32'h7);
    while (k < 90) begin
      step();
      case (k)
        1:  check("min_k1_rst_out", 32'(c_rst_out), 32'h1);
        2:  begin
              check("min_k2_rst_out", 32'(c_rst_out), 32'h0);
              check("min_k2_done", 32'(c_seq_done), 32'h0);
            end
        3:  check("min_k3_done", 32'(c_seq_done), 32'h1);
        15: check("k15_state_hold", 32'(seq_state), 32'h0);
        16: begin
              check("k16_state_wait", 32'(seq_state), 32'h1);
              check("k16_rst_out", 32'(rst_out), 32'h7);
            end
        19: check("k19_rst_out", 32'(rst_out), 32'h7);
        20: begin
              check("k20_rst_out", 32'(rst_out), 32'h6);
              check("k20_state_release", 32'(seq_state), 32'h2);
            end
        27: check("k27_rst_out", 32'(rst_out), 32'h6);
        28: check("k28_rst_out", 32'(rst_out), 32'h4);
        35: check("k35_rst_out", 32'(rst_out), 32'h4);
        36: begin
              check("k36_rst_out", 32'(rst_out), 32'h0);
              check("k36_state_run", 32'(seq_state), 32'h3);
              check("k36_done", 32'(seq_done), 32'h0);
            end
        37: check("k37_done", 32'(seq_done), 32'h1);
        50: pll_locked = 1'b0;
        52: begin
              check("lockloss_k52_rst_out", 32'(rst_out), 32'h0);
              check("lockloss_k52_done", 32'(seq_done), 32'h1);
            end
        53: begin
              check("lockloss_k53_rst_out", 32'(rst_out), 32'h7);
              check("lockloss_k53_done", 32'(seq_done), 32'h0);
              check("lockloss_k53_state", 32'(seq_state), 32'h0);
              pll_locked = 1'b1;
            end
        72: check("reseq_k72_rst_out", 32'(rst_out), 32'h7);
        73: check("reseq_k73_rst_out", 32'(rst_out), 32'h6);
        81: check("reseq_k81_rst_out", 32'(rst_out), 32'h4);
        89: check("reseq_k89_rst_out", 32'(rst_out), 32'h0);
        90: check("reseq_k90_done", 32'(seq_done), 32'h1);
        default: ;
      endcase
    end

    // Async reset pulse mid-RELEASE, then a clean restart.
    rst = 1'b1;
    tick();
    start_seq();
    while (k < 30) step();
    check("midrel_k30_rst_out", 32'(rst_out), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("midrel_async_rst_out", 32'(rst_out), 32'h7);
    check("midrel_async_done", 32'(seq_done), 32'h0);
    check("midrel_async_state", 32'(seq_state), 32'h0);
    tick();
    start_seq();
    while (k < 37) begin
      step();
      case (k)
        19: check("restart_k19_rst_out", 32'(rst_out), 32'h7);
        20: check("restart_k20_rst_out", 32'(rst_out), 32'h6);
        28: check("restart_k28_rst_out", 32'(rst_out), 32'h4);
        36: check("restart_k36_rst_out", 32'(rst_out), 32'h0);
        37: check("restart_k37_done", 32'(seq_done), 32'h1);
        default: ;
      endcase
    end

    // Lock glitch while filtering in WAIT_LOCK delays the first release.
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (2) tick();
    start_seq();
    while (k < 90) begin
      step();
      case (k)
        20: pll_locked = 1'b1;
        23: pll_locked = 1'b0;
        24: pll_locked = 1'b1;
        26: begin
              check("glitch_k26_state", 32'(seq_state), 32'h1);
              check("glitch_k26_rst_out", 32'(rst_out), 32'h7);
            end
        29: check("glitch_k29_rst_out", 32'(rst_out), 32'h7);
        30: check("glitch_k30_rst_out", 32'(rst_out), 32'h6);
        46: begin
              check("glitch_k46_rst_out", 32'(rst_out), 32'h0);
              check("glitch_k46_state", 32'(seq_state), 32'h3);
            end
`ifdef SYS_RST_SOFT_REQ_EN
        50: soft_rst_req = 1'b1;
        51: begin
              check("soft_run_k51_rst_out", 32'(rst_out), 32'h7);
              check("soft_run_k51_state", 32'(seq_state), 32'h0);
              soft_rst_req = 1'b0;
            end
        60: soft_rst_req = 1'b1;
        61: begin
              check("soft_hold_k61_state", 32'(seq_state), 32'h0);
              soft_rst_req = 1'b0;
            end
        71: check("soft_hold_k71_rst_out", 32'(rst_out), 32'h7);
        80: check("soft_hold_k80_rst_out", 32'(rst_out), 32'h7);
        81: check("soft_hold_k81_rst_out", 32'(rst_out), 32'h6);
`endif
        default: ;
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
